// File: rtl/inv_chain_stim.sv
// inv_chain_stim: pulse-train driver for an inverter chain with synchronized return-edge counting.
module inv_chain_stim #(
  parameter int WIDTH_W = 16,
  parameter int COUNT_W = 8,
  parameter int EDGE_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH_W-1:0] high_cycles,
  input  logic [WIDTH_W-1:0] low_cycles,
  input  logic [COUNT_W-1:0] num_pulses,
  input  logic               idle_level,
  input  logic               myout,
  output logic               myin,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] pulses_sent,
  output logic [EDGE_W-1:0]  edges_seen
);
  typedef enum logic [1:0] {IDLE, ACTIVE, REST, FIN} state_t;
  state_t state_q, state_d;
  logic [WIDTH_W-1:0] cnt_q, cnt_d, hi_q, hi_d, lo_q, lo_d;
  logic [COUNT_W-1:0] n_q, n_d, pulses_q, pulses_d;
  logic [EDGE_W-1:0] edges_q, edges_d;
  logic idle_q, idle_d, myin_q, myin_d, busy_q, busy_d;
  logic [2:0] sync_q, sync_d;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    n_d      = n_q;
    idle_d   = idle_q;
    myin_d   = myin_q;
    busy_d   = busy_q;
    pulses_d = pulses_q;
    sync_d   = {sync_q[1:0], myout};
    // sync_q[1] is the synchronized sample, sync_q[2] its previous value
    edges_d  = ((busy_q || state_q == FIN) && (sync_q[1] ^ sync_q[2]) && !(&edges_q))
               ? edges_q + 1'b1 : edges_q;
    case (state_q)
      IDLE: begin
        myin_d = idle_level;
        if (start) begin
          hi_d     = high_cycles;
          lo_d     = low_cycles;
          n_d      = num_pulses;
          idle_d   = idle_level;
          pulses_d = '0;
          edges_d  = '0;
          if (high_cycles != '0 && low_cycles != '0 && num_pulses != '0) begin
            busy_d  = 1'b1;
            myin_d  = ~idle_level;
            cnt_d   = high_cycles - 1'b1;
            state_d = ACTIVE;
          end else begin
            state_d = FIN;
          end
        end
      end
      ACTIVE: begin
        if (abort) begin
          state_d = IDLE;
          myin_d  = idle_q;
          busy_d  = 1'b0;
          edges_d = edges_q;
        end else if (cnt_q == '0) begin
          pulses_d = pulses_q + 1'b1;
          myin_d   = idle_q;
          cnt_d    = lo_q - 1'b1;
          state_d  = REST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      REST: begin
        if (abort) begin
          state_d = IDLE;
          myin_d  = idle_q;
          busy_d  = 1'b0;
          edges_d = edges_q;
        end else if (cnt_q == '0) begin
          if (pulses_q == n_q) begin
            busy_d  = 1'b0;
            state_d = FIN;
          end else begin
            myin_d  = ~idle_q;
            cnt_d   = hi_q - 1'b1;
            state_d = ACTIVE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIN: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      n_q      <= '0;
      idle_q   <= 1'b0;
      myin_q   <= 1'b0;
      busy_q   <= 1'b0;
      pulses_q <= '0;
      edges_q  <= '0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      n_q      <= n_d;
      idle_q   <= idle_d;
      myin_q   <= myin_d;
      busy_q   <= busy_d;
      pulses_q <= pulses_d;
      edges_q  <= edges_d;
      sync_q   <= sync_d;
    end
  end
  assign myin        = myin_q;
  assign busy        = busy_q;
  assign done        = state_q == FIN;
  assign pulses_sent = pulses_q;
  assign edges_seen  = edges_q;
endmodule
